// File: rtl/program_mem_arbiter_pkg.sv
// Shared types and helpers for the program-memory read arbiter.
package program_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } arb_state_e;

    // Width of a grant index for n requesters (never below one bit).
    function automatic int unsigned grant_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/program_mem_arbiter_rr_picker.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping upward.
module rr_picker
    import program_mem_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned GW = grant_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic          any_req_c,
    output logic [GW-1:0] grant_c
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        any_req_c = |req;
        grant_c   = '0;
        idx       = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (req[idx]) begin
                grant_c = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read channel among NUM_CORES icaches.
module program_mem_arbiter
    import program_mem_arb_pkg::*;
#(
    parameter  int unsigned NUM_CORES             = 4,
    parameter  int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter  int unsigned PROGRAM_MEM_DATA_BITS = 16,
    localparam int unsigned GRANT_BITS            = grant_bits(NUM_CORES)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_CORES-1:0]                       core_read_valid,
    input  logic [NUM_CORES*PROGRAM_MEM_ADDR_BITS-1:0] core_read_address,
    output logic [NUM_CORES-1:0]                       core_read_ready,
    output logic [PROGRAM_MEM_DATA_BITS-1:0]           core_read_data,
    output logic                                       mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]           mem_read_address,
    input  logic                                       mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0]           mem_read_data,
    output logic [GRANT_BITS-1:0]                      grant_id,
    output logic                                       busy
);

    localparam int unsigned A = PROGRAM_MEM_ADDR_BITS;
    localparam int unsigned D = PROGRAM_MEM_DATA_BITS;

    arb_state_e             state, state_n;
    logic [GRANT_BITS-1:0]  rr_ptr, rr_ptr_n;
    logic [GRANT_BITS-1:0]  grant_id_n;
    logic                   mem_read_valid_n;
    logic [A-1:0]           mem_read_address_n;
    logic [NUM_CORES-1:0]   core_read_ready_n;
    logic [D-1:0]           core_read_data_n;
    logic                   busy_n;

    logic                   any_req_c;
    logic [GRANT_BITS-1:0]  pick_c;
    logic [A-1:0]           addr_slices [NUM_CORES];

    for (genvar g = 0; g < int'(NUM_CORES); g++) begin : g_addr
        assign addr_slices[g] = core_read_address[g*A +: A];
    end

    rr_picker #(.N(NUM_CORES)) u_rr_picker (
        .req       (core_read_valid),
        .ptr       (rr_ptr),
        .any_req_c (any_req_c),
        .grant_c   (pick_c)
    );

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_n            = state;
        rr_ptr_n           = rr_ptr;
        grant_id_n         = grant_id;
        mem_read_valid_n   = mem_read_valid;
        mem_read_address_n = mem_read_address;
        core_read_ready_n  = core_read_ready;
        core_read_data_n   = core_read_data;

        case (state)
            IDLE: begin
                if (any_req_c) begin
                    grant_id_n         = pick_c;
                    mem_read_address_n = addr_slices[pick_c];
                    mem_read_valid_n   = 1'b1;
                    state_n            = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_read_ready) begin
                    core_read_data_n  = mem_read_data;
                    mem_read_valid_n  = 1'b0;
                    core_read_ready_n = NUM_CORES'(1) << grant_id;
                    state_n           = RESPOND;
                end
            end
            RESPOND: begin
                core_read_ready_n = '0;
                rr_ptr_n          = (grant_id == GRANT_BITS'(NUM_CORES - 1))
                                    ? '0 : grant_id + GRANT_BITS'(1);
                state_n           = IDLE;
            end
            default: begin
                mem_read_valid_n  = 1'b0;
                core_read_ready_n = '0;
                state_n           = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // Single register bank; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant_id         <= '0;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            core_read_ready  <= '0;
            core_read_data   <= '0;
            busy             <= 1'b0;
        end else begin
            state            <= state_n;
            rr_ptr           <= rr_ptr_n;
            grant_id         <= grant_id_n;
            mem_read_valid   <= mem_read_valid_n;
            mem_read_address <= mem_read_address_n;
            core_read_ready  <= core_read_ready_n;
            core_read_data   <= core_read_data_n;
            busy             <= busy_n;
        end
    end

endmodule
